// File: rtl/fir_out_decimator.sv
// Decimates the FIR output stream, scales each kept sample by right shift plus saturation,
// and buffers it in a small FIFO behind a valid/ready port. Define DEC_ROUND_EN for round-half-up.
module fir_out_decimator #(
  parameter int IN_W       = 16,
  parameter int OUT_W      = 8,
  parameter int SHIFT      = 4,
  parameter int DEC_FACTOR = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          res,
  input  logic                          in_valid,
  input  logic [IN_W-1:0]               in_data,
  output logic                          out_valid,
  output logic [OUT_W-1:0]              out_data,
  input  logic                          out_ready,
  output logic                          ovf,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  localparam logic [7:0]    CNT_ZERO = 8'd0;
  localparam logic [7:0]    CNT_ONE  = 8'd1;
  localparam logic [7:0]    CNT_LAST = 8'(DEC_FACTOR - 1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
  localparam logic [IN_W:0] SAT_MAX  = (IN_W+1)'({OUT_W{1'b1}});
`ifdef DEC_ROUND_EN
  localparam logic [IN_W:0] RND_HALF = (IN_W+1)'(1) << (SHIFT - 1);
`endif

  // Shift at IN_W+1 bits so a rounding carry survives into the saturation compare.
  function automatic logic [OUT_W-1:0] scale_sat(input logic [IN_W-1:0] x);
    logic [IN_W:0] s;
`ifdef DEC_ROUND_EN
    s = ({1'b0, x} + RND_HALF) >> SHIFT;
`else
    s = {1'b0, x} >> SHIFT;
`endif
    if (s > SAT_MAX) scale_sat = {OUT_W{1'b1}};
    else             scale_sat = s[OUT_W-1:0];
  endfunction

  logic [7:0]       cnt_q, cnt_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             ovf_q, ovf_d;
  logic [OUT_W-1:0] mem_q [FIFO_DEPTH];

  logic             vld_p0;
  logic [OUT_W-1:0] samp_p0;
  logic             full, pop, push;

  // Stage p0: decimation select and scaling, combinational on the input sample
  assign vld_p0  = in_valid && (cnt_q == CNT_ZERO);
  assign samp_p0 = scale_sat(in_data);

  assign full = (level_q == LVL_FULL);
  assign pop  = out_valid && out_ready;
  assign push = vld_p0 && (!full || pop);

  always_comb begin
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (in_valid) cnt_d = (cnt_q == CNT_LAST) ? CNT_ZERO : cnt_q + CNT_ONE;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (vld_p0 && full && !pop) ovf_d = 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      cnt_q    <= CNT_ZERO;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // Stage p1: FIFO storage; contents are don't-care until level says otherwise
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= samp_p0;
  end

  assign out_valid = (level_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign ovf       = ovf_q;
  assign level     = level_q;

endmodule

// File: tb/tb_fir_out_decimator.sv
// Directed bench for fir_out_decimator: three instances (DEC_FACTOR 2, 1, 3) share clock and reset.
module tb_fir_out_decimator;

  logic clk = 1'b0;
  logic res = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance a: DEC_FACTOR=2, b: DEC_FACTOR=1, c: DEC_FACTOR=3
  logic        iv_a = 0, rdy_a = 0, ov_a, ovf_a;
  logic [15:0] id_a = 0;
  logic [7:0]  od_a;
  logic [2:0]  lv_a;
  logic        iv_b = 0, rdy_b = 0, ov_b, ovf_b;
  logic [15:0] id_b = 0;
  logic [7:0]  od_b;
  logic [2:0]  lv_b;
  logic        iv_c = 0, rdy_c = 0, ov_c, ovf_c;
  logic [15:0] id_c = 0;
  logic [7:0]  od_c;
  logic [2:0]  lv_c;

  fir_out_decimator #(.DEC_FACTOR(2)) u_a (
    .clk(clk), .res(res), .in_valid(iv_a), .in_data(id_a), .out_valid(ov_a),
    .out_data(od_a), .out_ready(rdy_a), .ovf(ovf_a), .level(lv_a));
  fir_out_decimator #(.DEC_FACTOR(1)) u_b (
    .clk(clk), .res(res), .in_valid(iv_b), .in_data(id_b), .out_valid(ov_b),
    .out_data(od_b), .out_ready(rdy_b), .ovf(ovf_b), .level(lv_b));
  fir_out_decimator #(.DEC_FACTOR(3)) u_c (
    .clk(clk), .res(res), .in_valid(iv_c), .in_data(id_c), .out_valid(ov_c),
    .out_data(od_c), .out_ready(rdy_c), .ovf(ovf_c), .level(lv_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: integer shift with optional half-LSB add, then clamp to 8 bits
  function automatic logic [7:0] ref_scale(input logic [15:0] x);
    int unsigned s;
    s = x;
`ifdef DEC_ROUND_EN
    s = s + 8;
`endif
    s = s >> 4;
    return (s > 255) ? 8'hFF : s[7:0];
  endfunction

  logic [15:0] sc_in  [6] = '{16'h0128, 16'h1000, 16'hFFFF, 16'h0FF8, 16'h0008, 16'h0FF0};
`ifdef DEC_ROUND_EN
  logic [7:0]  sc_exp [6] = '{8'h13, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'hFF};
`else
  logic [7:0]  sc_exp [6] = '{8'h12, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hFF};
`endif
  logic [15:0] fill   [5] = '{16'h0110, 16'h0220, 16'h0330, 16'h0440, 16'h0550};

  logic [7:0] q[$];
  int         mcnt;
  bit         movf, mpop, mfull;

  initial begin
    // Power-on reset
    tick();
    chk("por_valid", ov_a, 0);
    chk("por_level", lv_a, 0);
    chk("por_ovf",   ovf_a, 0);
    chk("por_data",  od_a, 0);
    res = 0;

    // Reset mid-operation on instance a
    iv_a = 1; id_a = 16'h0100; rdy_a = 0;
    repeat (3) tick();
    chk("rst_pre_level", lv_a, 2);
    res = 1;
    tick();
    chk("rst_valid", ov_a, 0);
    chk("rst_level", lv_a, 0);
    chk("rst_ovf",   ovf_a, 0);
    res = 0;

    // Decimation by 2 with consumer always ready
    rdy_a = 1;
    for (int i = 1; i <= 6; i++) begin
      id_a = 16'(i * 16);
      tick();
      chk($sformatf("dec_valid_%0d", i), ov_a, (i % 2));
      if (i % 2 == 1) chk($sformatf("dec_data_%0d", i), od_a, i);
    end
    iv_a = 0; id_a = 16'h0090;
    tick();
    chk("hold_valid", ov_a, 0);
    iv_a = 1; id_a = 16'h0070;
    tick();
    chk("hold_keep_data", od_a, 8'h07);
    iv_a = 0;

    // Scaling boundaries on instance b (every sample kept)
    iv_b = 1; rdy_b = 1;
    for (int i = 0; i < 6; i++) begin
      id_b = sc_in[i];
      tick();
      chk($sformatf("scale_%04h", sc_in[i]), od_b, sc_exp[i]);
      chk($sformatf("scale_lvl_%0d", i), lv_b, 1);
    end
    iv_b = 0;
    tick();
    chk("scale_drain", ov_b, 0);

    // Full FIFO, fifth push dropped
    res = 1; tick(); res = 0;
    iv_b = 1; rdy_b = 0;
    for (int i = 0; i < 5; i++) begin
      id_b = fill[i];
      tick();
      chk($sformatf("full_lvl_%0d", i), lv_b, (i < 4) ? i + 1 : 4);
      chk($sformatf("full_ovf_%0d", i), ovf_b, (i == 4) ? 1 : 0);
      chk($sformatf("full_head_%0d", i), od_b, 8'h11);
    end
    iv_b = 0;
    tick();
    chk("ovf_sticky", ovf_b, 1);

    // Full FIFO with simultaneous push and pop
    res = 1; tick(); res = 0;
    chk("ovf_cleared", ovf_b, 0);
    iv_b = 1; rdy_b = 0;
    for (int i = 0; i < 4; i++) begin
      id_b = fill[i];
      tick();
    end
    chk("fp_pre_level", lv_b, 4);
    id_b = fill[4]; rdy_b = 1;
    tick();
    chk("fp_level", lv_b, 4);
    chk("fp_ovf",   ovf_b, 0);
    chk("fp_head",  od_b, 8'h22);
    iv_b = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("fp_drain_lvl_%0d", i), lv_b, 3 - i);
      chk($sformatf("fp_drain_data_%0d", i), od_b, 8'h33 + 8'(i * 8'h11));
    end
    tick();
    chk("fp_empty", ov_b, 0);

    // Random backpressure on instance c against a queue model
    res = 1; tick(); res = 0;
    mcnt = 0; movf = 0;
    for (int n = 0; n < 110; n++) begin
      chk("bp_valid", ov_c, (q.size() != 0));
      chk("bp_level", lv_c, q.size());
      if (q.size() != 0) chk("bp_data", od_c, q[0]);
      iv_c  = (n < 100);
      id_c  = 16'($urandom_range(0, 16'hFFFF));
      rdy_c = (n >= 100) || ($urandom_range(0, 3) != 0);
      mpop  = (q.size() != 0) && rdy_c;
      mfull = (q.size() == 4);
      if (mpop) void'(q.pop_front());
      if (iv_c) begin
        if (mcnt == 0) begin
          if (mfull && !mpop) movf = 1;
          else q.push_back(ref_scale(id_c));
        end
        mcnt = (mcnt == 2) ? 0 : mcnt + 1;
      end
      tick();
    end
    chk("bp_final_level", lv_c, q.size());
    chk("bp_ovf", ovf_c, movf);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
